// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one RAM/ROM bus between two requesters. Port 0 is the CPU
//   load/store path and port 1 is the DMA/debug loader. Arbitration is
//   round-robin. The arbiter drives the bus strobes itself and holds each
//   access for WAIT_CYC extra strobe cycles.
//
// Ports
//   clk                  system clock, all logic on posedge
//   ena                  synchronous active-low reset (low = reset)
//   reqN/weN/addrN/wdataN  requester N request, direction, address, write data
//   ackN                 one-cycle completion pulse for requester N
//   rdataN               last read data returned to requester N
//   gntN                 requester N owns the bus
//   ram_addr/ram_wdata   bus address / write data (held while idle)
//   ram_rdata            bus read data
//   ram_rd/ram_wr        bus read / write strobes
//   busy                 arbiter is not idle
module mem_bus_arbiter #(
  parameter int AW       = 13,
  parameter int DW       = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic          clk,
  input  logic          ena,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  output logic          gnt0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          gnt1,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          ram_rd,
  output logic          ram_wr,
  output logic          busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  logic [1:0]    state_q,    state_d;
  logic [3:0]    cnt_q,      cnt_d;
  logic          last_gnt_q, last_gnt_d;
  logic          cur_q,      cur_d;       // port owning the current access
  logic          gnt0_q,     gnt0_d;
  logic          gnt1_q,     gnt1_d;
  logic          ack0_q,     ack0_d;
  logic          ack1_q,     ack1_d;
  logic          rd_q,       rd_d;
  logic          wr_q,       wr_d;
  logic [AW-1:0] addr_q,     addr_d;
  logic [DW-1:0] wdata_q,    wdata_d;
  logic [DW-1:0] rdata0_q,   rdata0_d;
  logic [DW-1:0] rdata1_q,   rdata1_d;

  logic sel;
  logic we_sel;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    cur_d      = cur_q;
    gnt0_d     = gnt0_q;
    gnt1_d     = gnt1_q;
    ack0_d     = ack0_q;
    ack1_d     = ack1_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    // Under contention the port that did not go last wins; otherwise the
    // single requester wins (req1 alone selects port 1).
    sel        = (req0 && req1) ? ~last_gnt_q : req1;
    we_sel     = sel ? we1 : we0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          cur_d   = sel;
          gnt0_d  = ~sel;
          gnt1_d  = sel;
          addr_d  = sel ? addr1 : addr0;
          wdata_d = sel ? wdata1 : wdata0;
          wr_d    = we_sel;
          rd_d    = ~we_sel;
          cnt_d   = WAIT_INIT;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (rd_q) begin
            if (cur_q) rdata1_d = ram_rdata;
            else       rdata0_d = ram_rdata;
          end
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ack0_d  = ~cur_q;
          ack1_d  = cur_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        last_gnt_d = cur_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!ena) begin
      // last_gnt starts at 1 so port 0 wins the first contention.
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      last_gnt_q <= 1'b1;
      cur_q      <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      cur_q      <= cur_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_rd    = rd_q;
  assign ram_wr    = wr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: three instances (WAIT_CYC = 1, 0, 15)
// share one set of inputs; directed vectors with hand-computed results.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        ena;
  logic        req0, we0, req1, we1;
  logic [12:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1, ram_rdata;

  logic        ack0_a [3];
  logic        ack1_a [3];
  logic        gnt0_a [3];
  logic        gnt1_a [3];
  logic [7:0]  rdata0_a [3];
  logic [7:0]  rdata1_a [3];
  logic [12:0] ram_addr_a [3];
  logic [7:0]  ram_wdata_a [3];
  logic        ram_rd_a [3];
  logic        ram_wr_a [3];
  logic        busy_a [3];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mem_bus_arbiter #(
      .AW(13), .DW(8), .WAIT_CYC(k == 0 ? 1 : (k == 1 ? 0 : 15))
    ) u_dut (
      .clk(clk), .ena(ena),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .ack0(ack0_a[k]), .rdata0(rdata0_a[k]), .gnt0(gnt0_a[k]),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .ack1(ack1_a[k]), .rdata1(rdata1_a[k]), .gnt1(gnt1_a[k]),
      .ram_addr(ram_addr_a[k]), .ram_wdata(ram_wdata_a[k]),
      .ram_rdata(ram_rdata), .ram_rd(ram_rd_a[k]), .ram_wr(ram_wr_a[k]),
      .busy(busy_a[k])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on the WAIT_CYC=1 instance, started from IDLE.
  task automatic run_acc(input logic p, input logic we, input logic [12:0] a,
                         input logic [7:0] wd, input logic [7:0] rdv,
                         input logic [7:0] exp_r0, input logic [7:0] exp_r1);
    if (!p) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
    else    begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
    ram_rdata = rdv;
    tick();
    // Inputs changed after the grant must have no effect.
    req0 = 1'b0; req1 = 1'b0; we0 = ~we; we1 = ~we;
    addr0 = 13'h0; addr1 = 13'h0; wdata0 = 8'h0; wdata1 = 8'h0;
    check("acc_gnt",    32'({gnt1_a[0], gnt0_a[0]}), p ? 32'h2 : 32'h1);
    check("acc_strobe", 32'({ram_wr_a[0], ram_rd_a[0]}), we ? 32'h2 : 32'h1);
    check("acc_addr",   32'(ram_addr_a[0]), 32'(a));
    if (we) check("acc_wdata", 32'(ram_wdata_a[0]), 32'(wd));
    tick();
    check("acc_strobe2", 32'({ram_wr_a[0], ram_rd_a[0]}), we ? 32'h2 : 32'h1);
    check("acc_noack",   32'({ack1_a[0], ack0_a[0]}), 32'h0);
    tick();
    check("acc_strobe_off", 32'({ram_wr_a[0], ram_rd_a[0]}), 32'h0);
    check("acc_ack",        32'({ack1_a[0], ack0_a[0]}), p ? 32'h2 : 32'h1);
    check("acc_rdata0",     32'(rdata0_a[0]), 32'(exp_r0));
    check("acc_rdata1",     32'(rdata1_a[0]), 32'(exp_r1));
    ram_rdata = 8'hEE;
    tick();
    check("acc_ack_off",  32'({ack1_a[0], ack0_a[0]}), 32'h0);
    check("acc_gnt_off",  32'({gnt1_a[0], gnt0_a[0]}), 32'h0);
    check("acc_idle",     32'(busy_a[0]), 32'h0);
    check("acc_hold0",    32'(rdata0_a[0]), 32'(exp_r0));
    check("acc_hold1",    32'(rdata1_a[0]), 32'(exp_r1));
  endtask

  initial begin
    int wv [3];
    int width [3];
    int ackc [3];
    bit done [3];
    bit overlap;
    bit ack1_seen;
    bit ack0_seen;
    wv = '{1, 0, 15};

    ena = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 13'h0; addr1 = 13'h0; wdata0 = 8'h0; wdata1 = 8'h0; ram_rdata = 8'h0;

    // Reset with both requests high
    req0 = 1'b1; req1 = 1'b1;
    tick(); tick();
    check("rst_gnt",    32'({gnt1_a[0], gnt0_a[0]}), 32'h0);
    check("rst_ack",    32'({ack1_a[0], ack0_a[0]}), 32'h0);
    check("rst_strobe", 32'({ram_wr_a[0], ram_rd_a[0]}), 32'h0);
    check("rst_addr",   32'(ram_addr_a[0]), 32'h0);
    check("rst_wdata",  32'(ram_wdata_a[0]), 32'h0);
    check("rst_rdata",  32'({rdata1_a[0], rdata0_a[0]}), 32'h0);
    check("rst_busy",   32'(busy_a[0]), 32'h0);

    // Contention: both held, four accesses of WAIT_CYC+3 = 4 cycles each
    ena = 1'b1;
    tick();
    overlap = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      if (gnt0_a[0] && gnt1_a[0]) overlap = 1'b1;
      if ((i % 4) == 0)
        check("cont_gnt", 32'({gnt1_a[0], gnt0_a[0]}), ((i / 4) % 2 == 0) ? 32'h1 : 32'h2);
      if ((i % 4) == 1) check("cont_busy", 32'(busy_a[0]), 32'h1);
      if ((i % 4) == 2)
        check("cont_ack", 32'({ack1_a[0], ack0_a[0]}), ((i / 4) % 2 == 0) ? 32'h1 : 32'h2);
      if ((i % 4) == 3) check("cont_idle", 32'(busy_a[0]), 32'h0);
      if (i == 15) begin req0 = 1'b0; req1 = 1'b0; end
    end
    check("cont_overlap", 32'(overlap), 32'h0);

    // Single accesses on WAIT_CYC=1
    ena = 1'b0; tick(); ena = 1'b1;
    run_acc(1'b0, 1'b0, 13'h00A5, 8'h00, 8'h3C, 8'h3C, 8'h00);
    run_acc(1'b1, 1'b0, 13'h0123, 8'h00, 8'h77, 8'h3C, 8'h77);
    run_acc(1'b1, 1'b1, 13'h1FFF, 8'hA5, 8'h99, 8'h3C, 8'h77);

    // Strobe width and ack latency for WAIT_CYC = 1, 0, 15
    ena = 1'b0; tick(); ena = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 13'h0042; ram_rdata = 8'h5A;
    for (int k = 0; k < 3; k++) begin width[k] = 0; ackc[k] = -1; done[k] = 1'b0; end
    tick();
    for (int c = 0; c < 25; c++) begin
      if (c > 0) tick();
      for (int k = 0; k < 3; k++) begin
        if (!done[k]) begin
          if (ram_rd_a[k]) width[k]++;
          else if (width[k] > 0) done[k] = 1'b1;
        end
        if (ack0_a[k] && ackc[k] < 0) ackc[k] = c;
      end
      if (c == 0) req0 = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      check("wait_width", 32'(width[k]), 32'(wv[k] + 1));
      check("wait_ack",   32'(ackc[k]),  32'(wv[k] + 1));
      check("wait_rdata", 32'(rdata0_a[k]), 32'h5A);
    end

    // Reset during a port 1 access
    ena = 1'b0; tick(); ena = 1'b1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 13'h0777;
    tick();
    req1 = 1'b0;
    check("mid_gnt1", 32'(gnt1_a[0]), 32'h1);
    check("mid_rd",   32'(ram_rd_a[0]), 32'h1);
    ena = 1'b0;
    tick();
    check("mid_rd_drop", 32'(ram_rd_a[0]), 32'h0);
    check("mid_gnt_off", 32'({gnt1_a[0], gnt0_a[0]}), 32'h0);
    check("mid_noack",   32'(ack1_a[0]), 32'h0);
    check("mid_busy",    32'(busy_a[0]), 32'h0);
    ena = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    check("mid_regrant", 32'({gnt1_a[0], gnt0_a[0]}), 32'h1);
    ack1_seen = 1'b0; ack0_seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ack1_a[0]) ack1_seen = 1'b1;
      if (ack0_a[0]) ack0_seen = 1'b1;
    end
    check("mid_ack1_never", 32'(ack1_seen), 32'h0);
    check("mid_ack0_after", 32'(ack0_seen), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
